wb_trace_buffer: RTL and testbench
==================================

Name: wb_trace_buffer

Overview:
Synthesisable writeback-trace capture block that replaces ad-hoc bench printing of pipeline WB results. It sits beside the CPU top and snoops the writeback stage (valid, PC, result). Qualifying commits are stored, each with a cycle timestamp, in a parametrised FIFO that an external reader drains through a valid/ready handshake. It supports a bounded capture window, optional zero-result filtering, and a selectable full-buffer policy.

Parameters:
DATA_W, 32, width of the WB result
PC_W, 32, width of the PC
DEPTH, 16, number of entries; power of two, at least 2
CYC_W, 16, width of the capture-cycle timestamp and the window length

Ports:
clk  in  1  system clock; all state updates on the rising edge
rst_n  in  1  asynchronous, active-low reset
start  in  1  single-cycle pulse that enters CAPTURE and clears the cycle counter
flush  in  1  single-cycle pulse that empties the FIFO and clears overflow_cnt
cfg_filter_zero  in  1  1: drop commits whose result is 0
cfg_overwrite  in  1  0: drop new entries when full; 1: overwrite the oldest entry
cfg_max_cycles  in  CYC_W  capture window length in cycles; 0 means unlimited
wb_valid  in  1  WB stage is committing this cycle
wb_pc  in  PC_W  PC of the committing instruction
wb_result  in  DATA_W  WB result value
rd_valid  out  1  head entry is available
rd_ready  in  1  reader accepts the head entry
rd_pc  out  PC_W  PC of the head entry
rd_result  out  DATA_W  result of the head entry
rd_cycle  out  CYC_W  timestamp of the head entry
count  out  $clog2(DEPTH+1)  current occupancy
overflow_cnt  out  16  number of dropped or overwritten entries; saturates at 0xFFFF
capturing  out  1  FSM is in CAPTURE
done  out  1  FSM is in DONE

Behaviour:
- Reset (async on rst_n low): FSM=IDLE, FIFO pointers=0, count=0, overflow_cnt=0, cycle counter=0. All outputs are 0 during reset, including rd_pc, rd_result and rd_cycle.
- FSM states:
  - IDLE: entered from reset. start -> CAPTURE.
  - CAPTURE: cycle counter increments every cycle, starting at 0 on the first CAPTURE cycle. When cfg_max_cycles != 0 and the counter equals cfg_max_cycles-1, the next state is DONE. The counter saturates at all-ones.
  - DONE: start -> CAPTURE, with the counter cleared and FIFO contents retained.
  - start while already in CAPTURE restarts the window by clearing the counter.
- Qualify: wb_valid && capturing && !(cfg_filter_zero && wb_result==0). A qualifying commit is written with {wb_pc, wb_result, counter value in that same cycle}.
- FIFO is first-word-fall-through:
  - rd_* present the head entry combinationally from storage; rd_valid = (count != 0).
  - Pop occurs when rd_valid && rd_ready.
  - Write-to-visible latency is 1 cycle: an entry written at edge N appears on rd_* after edge N.
- Full handling (count==DEPTH with a qualifying write):
  - Pop in the same cycle: the write is accepted, count is unchanged, overflow_cnt is not incremented.
  - No pop and cfg_overwrite=0: the write is dropped and overflow_cnt increments.
  - No pop and cfg_overwrite=1: both read and write pointers advance, the oldest entry is lost, count stays at DEPTH, and overflow_cnt increments.
- Empty with a qualifying write: the write is accepted. rd_valid is 0 in that cycle, so no pop can occur.
- Pointers are log2(DEPTH) bits and wrap naturally. Occupancy is tracked by a separate count register.
- flush has priority over writes and pops in the same cycle: pointers and count go to 0 and overflow_cnt goes to 0. The FSM state is unaffected.
- Pops are allowed in every FSM state, so the reader can drain in IDLE or DONE.
- Reset mid-capture discards all contents and returns the FSM to IDLE.

Decomposition:
- Shared package wb_trace_pkg:
  - FSM state enum: IDLE, CAPTURE, DONE.
  - Entry struct {pc, result, cycle}.
  - OVF_W=16 constant.
- Sub-module trace_fifo holds the storage array, pointers, count, and the full/overwrite logic. It is parametrised by the entry width and DEPTH.
- The top level holds the FSM, cycle counter, qualify logic and overflow counter.

Test Plan:
- Basic capture and drain:
  - Stimulus: reset, start, cfg_max_cycles=20, filter=1; WB commits (pc 0x0,res 5), (0x4,0), (0x8,10) on cycles 2, 3, 4 of CAPTURE.
  - Required: exactly two entries, {0x0,5,2} and {0x8,10,4}.
  - Required: done asserts after cycle 19 of CAPTURE, i.e. on the 21st edge counting from start.
- Filter disabled:
  - Stimulus: same sequence with filter=0.
  - Required: three entries, including {0x4,0,3}.
- Drop policy:
  - Stimulus: DEPTH=4, overwrite=0, rd_ready=0, 6 qualifying commits with results 1 to 6.
  - Required: count=4, overflow_cnt=2, drained results 1,2,3,4.
- Overwrite policy:
  - Stimulus: same as the drop test with overwrite=1.
  - Required: count=4, overflow_cnt=2, drained results 3,4,5,6.
- Full with simultaneous pop and write:
  - Stimulus: FIFO full with rd_ready=1 during a qualifying write.
  - Required: count stays 4, overflow_cnt unchanged, order preserved.
- Async reset and flush:
  - Stimulus: rst_n driven low mid-CAPTURE between clock edges.
  - Required: count=0, rd_valid=0, capturing=0 immediately, without waiting for a clock edge.
  - Stimulus: separately, flush asserted together with a write.
  - Required: count=0 after the edge.

Source files
------------

// File: rtl/wb_trace_pkg.sv
// Shared types and constants for the writeback trace buffer.
// The entry struct depends on module parameters, so it is declared in the top.
package wb_trace_pkg;

  localparam int OVF_W = 16;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CAPTURE = 2'd1,
    DONE    = 2'd2
  } state_t;

endpackage

// File: rtl/trace_fifo.sv
// First-word-fall-through FIFO with a selectable full-buffer policy (drop or overwrite oldest).
// Storage is not reset; the head output is forced to zero while the FIFO is empty.
module trace_fifo #(
  parameter int ENTRY_W = 80,
  parameter int DEPTH   = 16
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       flush,
  input  logic                       wr_en,
  input  logic [ENTRY_W-1:0]         wr_data,
  input  logic                       overwrite,
  input  logic                       rd_ready,
  output logic                       rd_valid,
  output logic [ENTRY_W-1:0]         rd_data,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       lost
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH+1);

  logic [ENTRY_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]   wptr;
  logic [PTR_W-1:0]   rptr;
  logic               full;
  logic               pop;
  logic               accept;
  logic               evict;

  assign full     = (count == CNT_W'(DEPTH));
  assign rd_valid = (count != '0);
  assign pop      = rd_valid && rd_ready;
  assign accept   = wr_en && (!full || pop || overwrite);
  // Overwrite on a full FIFO: the write lands on the oldest slot and the head skips past it.
  assign evict    = wr_en && full && !pop && overwrite;
  assign lost     = wr_en && full && !pop;
  assign rd_data  = rd_valid ? mem[rptr] : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else if (flush) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (accept)
        wptr <= wptr + 1'b1;
      if (pop || evict)
        rptr <= rptr + 1'b1;
      case ({accept && !evict, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (accept && !flush)
      mem[wptr] <= wr_data;
  end

endmodule

// File: rtl/wb_trace_buffer.sv
// Writeback trace capture: snoops WB commits during a capture window and queues
// {pc, result, timestamp} entries for an external valid/ready reader.
module wb_trace_buffer
  import wb_trace_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int PC_W   = 32,
  parameter int DEPTH  = 16,
  parameter int CYC_W  = 16
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       start,
  input  logic                       flush,
  input  logic                       cfg_filter_zero,
  input  logic                       cfg_overwrite,
  input  logic [CYC_W-1:0]           cfg_max_cycles,
  input  logic                       wb_valid,
  input  logic [PC_W-1:0]            wb_pc,
  input  logic [DATA_W-1:0]          wb_result,
  output logic                       rd_valid,
  input  logic                       rd_ready,
  output logic [PC_W-1:0]            rd_pc,
  output logic [DATA_W-1:0]          rd_result,
  output logic [CYC_W-1:0]           rd_cycle,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic [OVF_W-1:0]           overflow_cnt,
  output logic                       capturing,
  output logic                       done
);

  typedef struct packed {
    logic [PC_W-1:0]   pc;
    logic [DATA_W-1:0] result;
    logic [CYC_W-1:0]  cycle;
  } entry_t;

  localparam int ENTRY_W = $bits(entry_t);

  function automatic logic [CYC_W-1:0] sat_inc_cyc(input logic [CYC_W-1:0] v);
    return (v == '1) ? v : v + 1'b1;
  endfunction

  function automatic logic [OVF_W-1:0] sat_inc_ovf(input logic [OVF_W-1:0] v);
    return (v == '1) ? v : v + 1'b1;
  endfunction

  state_t           state;
  state_t           state_nx;
  logic [CYC_W-1:0] cyc;
  logic             qualify;
  logic             lost;
  entry_t           wr_entry;
  entry_t           head;
  logic [ENTRY_W-1:0] head_bits;

  assign capturing = (state == CAPTURE);
  assign done      = (state == DONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      state <= IDLE;
    else
      state <= state_nx;
  end

  // A start pulse in CAPTURE only restarts the window, so it also blocks the DONE exit.
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (start) state_nx = CAPTURE;
      CAPTURE: if (!start && cfg_max_cycles != '0 && cyc == cfg_max_cycles - 1'b1)
                 state_nx = DONE;
      DONE:    if (start) state_nx = CAPTURE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      cyc <= '0;
    else if (start)
      cyc <= '0;
    else if (capturing)
      cyc <= sat_inc_cyc(cyc);
  end

  assign qualify  = wb_valid && capturing && !(cfg_filter_zero && wb_result == '0);
  assign wr_entry = '{pc: wb_pc, result: wb_result, cycle: cyc};

  trace_fifo #(
    .ENTRY_W (ENTRY_W),
    .DEPTH   (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .wr_en     (qualify),
    .wr_data   (wr_entry),
    .overwrite (cfg_overwrite),
    .rd_ready  (rd_ready),
    .rd_valid  (rd_valid),
    .rd_data   (head_bits),
    .count     (count),
    .lost      (lost)
  );

  assign head      = head_bits;
  assign rd_pc     = head.pc;
  assign rd_result = head.result;
  assign rd_cycle  = head.cycle;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      overflow_cnt <= '0;
    else if (flush)
      overflow_cnt <= '0;
    else if (lost)
      overflow_cnt <= sat_inc_ovf(overflow_cnt);
  end

endmodule

// File: tb/tb_wb_trace_buffer.sv
// Bench for wb_trace_buffer: directed scenarios plus random traffic against a queue-based model.
module tb_wb_trace_buffer;

  localparam int DATA_W = 32;
  localparam int PC_W   = 32;
  localparam int DEPTH  = 4;
  localparam int CYC_W  = 16;
  localparam int CNT_W  = $clog2(DEPTH+1);
  localparam int M_IDLE = 0, M_CAP = 1, M_DONE = 2;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              start = 1'b0;
  logic              flush = 1'b0;
  logic              cfg_filter_zero = 1'b0;
  logic              cfg_overwrite = 1'b0;
  logic [CYC_W-1:0]  cfg_max_cycles = '0;
  logic              wb_valid = 1'b0;
  logic [PC_W-1:0]   wb_pc = '0;
  logic [DATA_W-1:0] wb_result = '0;
  logic              rd_ready = 1'b0;
  logic              rd_valid;
  logic [PC_W-1:0]   rd_pc;
  logic [DATA_W-1:0] rd_result;
  logic [CYC_W-1:0]  rd_cycle;
  logic [CNT_W-1:0]  count;
  logic [15:0]       overflow_cnt;
  logic              capturing;
  logic              done;

  wb_trace_buffer #(
    .DATA_W (DATA_W), .PC_W (PC_W), .DEPTH (DEPTH), .CYC_W (CYC_W)
  ) dut (
    .clk (clk), .rst_n (rst_n), .start (start), .flush (flush),
    .cfg_filter_zero (cfg_filter_zero), .cfg_overwrite (cfg_overwrite),
    .cfg_max_cycles (cfg_max_cycles), .wb_valid (wb_valid), .wb_pc (wb_pc),
    .wb_result (wb_result), .rd_valid (rd_valid), .rd_ready (rd_ready),
    .rd_pc (rd_pc), .rd_result (rd_result), .rd_cycle (rd_cycle),
    .count (count), .overflow_cnt (overflow_cnt), .capturing (capturing), .done (done)
  );

  always #5 clk = ~clk;

  typedef struct {
    longint unsigned pc;
    longint unsigned res;
    longint unsigned cyc;
  } ent_t;

  ent_t        q[$];
  int          m_mode;
  int unsigned m_cyc;
  int unsigned m_ovf;
  int          total = 0;
  int          bad = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_mode = M_IDLE;
    m_cyc  = 0;
    m_ovf  = 0;
  endtask

  // Applies one clock edge worth of behaviour to the model using the current inputs.
  task automatic model_edge();
    ent_t e;
    bit   qual;
    bit   pop;
    int   maxc;
    maxc = int'(cfg_max_cycles);
    qual = wb_valid && (m_mode == M_CAP) && !(cfg_filter_zero && wb_result == 0);
    pop  = (q.size() != 0) && rd_ready;
    e.pc  = wb_pc;
    e.res = wb_result;
    e.cyc = m_cyc;
    if (flush) begin
      q.delete();
      m_ovf = 0;
    end else begin
      if (pop) void'(q.pop_front());
      if (qual) begin
        if (q.size() < DEPTH) begin
          q.push_back(e);
        end else begin
          if (m_ovf < 65535) m_ovf++;
          if (cfg_overwrite) begin
            void'(q.pop_front());
            q.push_back(e);
          end
        end
      end
    end
    if (start) begin
      m_mode = M_CAP;
      m_cyc  = 0;
    end else if (m_mode == M_CAP) begin
      if (maxc != 0 && m_cyc == maxc - 1) m_mode = M_DONE;
      if (m_cyc < (1 << CYC_W) - 1) m_cyc++;
    end
  endtask

  task automatic compare_all();
    chk("capturing", capturing, m_mode == M_CAP);
    chk("done", done, m_mode == M_DONE);
    chk("count", count, q.size());
    chk("overflow_cnt", overflow_cnt, m_ovf);
    chk("rd_valid", rd_valid, q.size() != 0);
    if (q.size() != 0) begin
      chk("rd_pc", rd_pc, q[0].pc);
      chk("rd_result", rd_result, q[0].res);
      chk("rd_cycle", rd_cycle, q[0].cyc);
    end else begin
      chk("rd_pc_empty", rd_pc, 0);
      chk("rd_result_empty", rd_result, 0);
      chk("rd_cycle_empty", rd_cycle, 0);
    end
  endtask

  task automatic step();
    model_edge();
    @(posedge clk);
    #1;
    compare_all();
  endtask

  task automatic commit(input int unsigned pc, input int unsigned res);
    wb_valid  = 1'b1;
    wb_pc     = PC_W'(pc);
    wb_result = DATA_W'(res);
    step();
    wb_valid  = 1'b0;
  endtask

  task automatic do_flush();
    flush = 1'b1;
    step();
    flush = 1'b0;
  endtask

  task automatic run_window(input bit filt);
    cfg_filter_zero = filt;
    start = 1'b1;
    step();
    start = 1'b0;
    for (int k = 0; k < 20; k++) begin
      wb_valid  = (k >= 2 && k <= 4);
      wb_pc     = PC_W'((k - 2) * 4);
      wb_result = (k == 2) ? 32'd5 : (k == 3) ? 32'd0 : 32'd10;
      step();
      if (k == 18) chk("done_edge20", done, 0);
      if (k == 19) chk("done_edge21", done, 1);
    end
    wb_valid = 1'b0;
  endtask

  initial begin
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    compare_all();
    rst_n = 1'b1;

    // Basic capture with zero filtering
    cfg_max_cycles = 16'd20;
    run_window(1'b1);
    chk("t1_count", count, 2);
    chk("t1_head_pc", rd_pc, 0);
    chk("t1_head_res", rd_result, 5);
    chk("t1_head_cyc", rd_cycle, 2);
    rd_ready = 1'b1;
    step();
    chk("t1_second_pc", rd_pc, 8);
    chk("t1_second_res", rd_result, 10);
    chk("t1_second_cyc", rd_cycle, 4);
    step();
    rd_ready = 1'b0;
    chk("t1_empty", rd_valid, 0);

    // Filter disabled: the zero-result commit is kept
    run_window(1'b0);
    chk("t2_count", count, 3);
    rd_ready = 1'b1;
    step();
    rd_ready = 1'b0;
    chk("t2_mid_pc", rd_pc, 4);
    chk("t2_mid_res", rd_result, 0);
    chk("t2_mid_cyc", rd_cycle, 3);
    do_flush();

    // Drop and overwrite policies
    cfg_max_cycles  = '0;
    cfg_filter_zero = 1'b0;
    for (int pol = 0; pol < 2; pol++) begin
      cfg_overwrite = 1'(pol);
      do_flush();
      start = 1'b1;
      step();
      start = 1'b0;
      for (int i = 1; i <= 6; i++) commit(4 * i, i);
      chk("pol_count", count, 4);
      chk("pol_ovf", overflow_cnt, 2);
      rd_ready = 1'b1;
      for (int i = 1; i <= 4; i++) begin
        chk("pol_drain", rd_result, (pol == 0) ? i : i + 2);
        step();
      end
      rd_ready = 1'b0;
    end

    // Full FIFO with simultaneous pop and write
    cfg_overwrite = 1'b0;
    do_flush();
    for (int i = 1; i <= 4; i++) commit(4 * i, i);
    rd_ready = 1'b1;
    commit(20, 5);
    chk("fpw_count", count, 4);
    chk("fpw_ovf", overflow_cnt, 0);
    for (int i = 2; i <= 5; i++) begin
      chk("fpw_order", rd_result, i);
      step();
    end
    rd_ready = 1'b0;

    // Flush wins over a same-cycle write
    commit(100, 9);
    flush = 1'b1;
    commit(104, 11);
    flush = 1'b0;
    chk("flush_count", count, 0);
    chk("flush_valid", rd_valid, 0);

    // Random traffic
    for (int n = 0; n < 1500; n++) begin
      start = ($urandom_range(0, 39) == 0);
      flush = ($urandom_range(0, 59) == 0);
      if ($urandom_range(0, 99) == 0)
        cfg_max_cycles = ($urandom_range(0, 3) == 0) ? '0 : CYC_W'($urandom_range(5, 40));
      if ($urandom_range(0, 49) == 0) cfg_overwrite = ~cfg_overwrite;
      if ($urandom_range(0, 49) == 0) cfg_filter_zero = ~cfg_filter_zero;
      wb_valid  = 1'($urandom_range(0, 1));
      wb_pc     = PC_W'($urandom);
      wb_result = ($urandom_range(0, 3) == 0) ? '0 : DATA_W'($urandom);
      rd_ready  = ($urandom_range(0, 9) < 4);
      step();
    end
    start = 1'b0;
    flush = 1'b0;
    wb_valid = 1'b0;
    rd_ready = 1'b0;

    // Asynchronous reset in the middle of a capture window
    cfg_max_cycles = '0;
    cfg_filter_zero = 1'b0;
    start = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < 3; i++) commit(32'h40 + 4 * i, 32'h77 + i);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_count", count, 0);
    chk("arst_valid", rd_valid, 0);
    chk("arst_capturing", capturing, 0);
    chk("arst_rd_pc", rd_pc, 0);
    chk("arst_ovf", overflow_cnt, 0);
    model_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    compare_all();
    for (int i = 0; i < 3; i++) step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
